// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams element pairs from two vector RAMs into the shared MAC,
// then captures the final accumulator into a held result with a one-cycle done pulse.
module mac_dot_seq #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 10,
    parameter int unsigned ACC_W  = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        a_rdata,
    input  logic [7:0]        b_rdata,
    output logic [7:0]        mac_in1,
    output logic [7:0]        mac_in2,
    output logic              mac_clr,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result
);

    localparam int unsigned SUM_W = ADDR_W + LEN_W;

    typedef enum logic [2:0] {
        st_idle,
        st_clear,
        st_feed,
        st_drain,
        st_done
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    idx;
    logic [ADDR_W-1:0]   a_base_q;
    logic [ADDR_W-1:0]   b_base_q;
    logic                rv;
    logic [LEN_W-1:0]    len_last;
    logic [SUM_W-1:0]    a_sum;
    logic [SUM_W-1:0]    b_sum;

    assign len_last = len_q - LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= st_idle;
            len_q    <= '0;
            idx      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            rv       <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            rv   <= rd_en;
            done <= 1'b0;
            unique case (state)
                st_idle: begin
                    if (start) begin
                        len_q    <= len;
                        a_base_q <= a_base;
                        b_base_q <= b_base;
                        idx      <= '0;
                        state    <= st_clear;
                    end
                end
                st_clear: begin
                    if (len_q != '0) begin
                        idx <= LEN_W'(1);
                    end
                    if (len_q == '0) begin
                        state <= st_done;
                    end else if (len_q == LEN_W'(1)) begin
                        state <= st_drain;
                    end else begin
                        state <= st_feed;
                    end
                end
                st_feed: begin
                    idx <= idx + LEN_W'(1);
                    if (idx == len_last) begin
                        state <= st_drain;
                    end
                end
                st_drain: begin
                    state <= st_done;
                end
                st_done: begin
                    result <= mac_acc;
                    done   <= 1'b1;
                    state  <= st_idle;
                end
                default: begin
                    state <= st_idle;
                end
            endcase
        end
    end

    // Reads are issued in CLEAR (first element) and every FEED cycle.
    always_comb begin
        rd_en = 1'b0;
        if (state == st_feed) begin
            rd_en = 1'b1;
        end else if (state == st_clear && len_q != '0) begin
            rd_en = 1'b1;
        end
    end

    assign a_sum  = SUM_W'(a_base_q) + SUM_W'(idx);
    assign b_sum  = SUM_W'(b_base_q) + SUM_W'(idx);
    assign a_addr = a_sum[ADDR_W-1:0];
    assign b_addr = b_sum[ADDR_W-1:0];

    // The MAC accumulates every cycle, so operands must be zero unless a pair is valid.
    assign mac_in1 = rv ? a_rdata : 8'd0;
    assign mac_in2 = rv ? b_rdata : 8'd0;
    assign mac_clr = rst | (state == st_clear);
    assign busy    = (state != st_idle);

endmodule
